// File: rtl/seven_seg_judge.sv
// seven_seg_judge: read-back judge for the 7-segment slot game.
// Decodes the six active-low HEX buses back into digits. It waits until the
// buses have been unchanged for STABLE_CYCLES cycles while all reels are
// stopped. It then scores the spin once and keeps a saturating win counter.
// Optional feature macro: JUDGE_ERR_EN adds the oErr port. With it, any
// undecodable segment pattern is reported instead of scored.
// FSM state is held in r_state (state_t) for debug visibility.
module seven_seg_judge #(
  parameter int STABLE_CYCLES = 1000,
  parameter int WIN_CNT_W     = 8
) (
  input  logic                 iClk,
  input  logic                 iRst_n,
  input  logic [41:0]          iHex,
  input  logic                 iAllDisabled,
  output logic [23:0]          oDigits,
  output logic                 oValid,
  output logic [2:0]           oMatchCnt,
  output logic                 oWin,
  output logic [WIN_CNT_W-1:0] oWinCount
`ifdef JUDGE_ERR_EN
  ,
  output logic                 oErr
`endif
);

  localparam logic [15:0] LP_STABLE = 16'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_JUDGE  = 2'd2,
    ST_RESULT = 2'd3
  } state_t;

  state_t               r_state;
  logic [41:0]          r_hex_q;
  logic [15:0]          r_stab_cnt;
  logic [23:0]          r_digits;
  logic                 r_valid;
  logic [2:0]           r_match_cnt;
  logic                 r_win;
  logic [WIN_CNT_W-1:0] r_win_cnt;

  logic                 w_hex_chg;
  logic [23:0]          w_dig;
  logic [2:0]           w_match;

  // Active-low segment pattern to digit; unknown patterns read as 0.
  function automatic logic [3:0] seg_digit(input logic [6:0] seg);
    case (seg)
      7'h40:   return 4'h0;
      7'h79:   return 4'h1;
      7'h24:   return 4'h2;
      7'h30:   return 4'h3;
      7'h19:   return 4'h4;
      7'h12:   return 4'h5;
      7'h02:   return 4'h6;
      7'h78:   return 4'h7;
      7'h00:   return 4'h8;
      7'h10:   return 4'h9;
      7'h08:   return 4'hA;
      7'h03:   return 4'hB;
      7'h46:   return 4'hC;
      7'h21:   return 4'hD;
      7'h06:   return 4'hE;
      7'h0E:   return 4'hF;
      default: return 4'h0;
    endcase
  endfunction

`ifdef JUDGE_ERR_EN
  logic       r_err;
  logic [5:0] w_ok;

  // High when the segment pattern is one of the sixteen legal glyphs.
  function automatic logic seg_known(input logic [6:0] seg);
    case (seg)
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E:
        return 1'b1;
      default:
        return 1'b0;
    endcase
  endfunction

  // Per-digit validity of the settled snapshot.
  always_comb begin
    w_ok = '0;
    for (int i = 0; i < 6; i++) begin
      w_ok[i] = seg_known(r_hex_q[i*7 +: 7]);
    end
  end

  assign oErr = r_err;
`endif

  assign w_hex_chg = (iHex != r_hex_q);

  // Decode the settled snapshot and count digits equal to d0 (d0 included).
  always_comb begin
    w_dig   = '0;
    w_match = '0;
    for (int i = 0; i < 6; i++) begin
      w_dig[i*4 +: 4] = seg_digit(r_hex_q[i*7 +: 7]);
    end
    for (int i = 0; i < 6; i++) begin
      if (w_dig[i*4 +: 4] == w_dig[3:0]) begin
        w_match = w_match + 3'd1;
      end
    end
  end

  // Input snapshot and saturating stability counter.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_hex_q    <= '0;
      r_stab_cnt <= '0;
    end else begin
      r_hex_q <= iHex;
      if (w_hex_chg) begin
        r_stab_cnt <= '0;
      end else if (r_stab_cnt != LP_STABLE) begin
        r_stab_cnt <= r_stab_cnt + 16'd1;
      end
    end
  end

  // Judge FSM with registered results; oValid pulses on entry to RESULT.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state     <= ST_IDLE;
      r_digits    <= '0;
      r_valid     <= 1'b0;
      r_match_cnt <= '0;
      r_win       <= 1'b0;
      r_win_cnt   <= '0;
`ifdef JUDGE_ERR_EN
      r_err       <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (iAllDisabled) begin
            r_state <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (!iAllDisabled) begin
            r_state <= ST_IDLE;
          end else if (r_stab_cnt == LP_STABLE) begin
            r_state <= ST_JUDGE;
          end
        end
        ST_JUDGE: begin
          r_state  <= ST_RESULT;
          r_valid  <= 1'b1;
          r_digits <= w_dig;
`ifdef JUDGE_ERR_EN
          if (!(&w_ok)) begin
            r_err       <= 1'b1;
            r_win       <= 1'b0;
            r_match_cnt <= '0;
          end else begin
            r_err       <= 1'b0;
            r_match_cnt <= w_match;
            r_win       <= (w_match == 3'd6);
            if ((w_match == 3'd6) && (r_win_cnt != {WIN_CNT_W{1'b1}})) begin
              r_win_cnt <= r_win_cnt + 1'b1;
            end
          end
`else
          r_match_cnt <= w_match;
          r_win       <= (w_match == 3'd6);
          if ((w_match == 3'd6) && (r_win_cnt != {WIN_CNT_W{1'b1}})) begin
            r_win_cnt <= r_win_cnt + 1'b1;
          end
`endif
        end
        ST_RESULT: begin
          if (!iAllDisabled) begin
            r_state <= ST_IDLE;
            r_win   <= 1'b0;
`ifdef JUDGE_ERR_EN
            r_err   <= 1'b0;
`endif
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign oDigits   = r_digits;
  assign oValid    = r_valid;
  assign oMatchCnt = r_match_cnt;
  assign oWin      = r_win;
  assign oWinCount = r_win_cnt;

endmodule
